axi4_lite_rr_arbiter: RTL
=========================

// Module: axi4_lite_rr_arbiter
// PURPOSE
// - Shares one AXI4-Lite slave port between NUM_MASTERS AXI4-Lite master ports.
// - Write and read paths are independent, each with its own round-robin arbiter and FSM.
// - Each path has one transaction in flight at a time, so responses need no ID routing.
// - Sits between the master agents/bus bridges and one Axi4LiteInterface-attached slave.
// PARAMETERS
// NUM_MASTERS    2   number of upstream masters (2..8)
// ADDRESS_WIDTH  32  AXI address width (Axi4LiteGlobalsPkg value)
// DATA_WIDTH     32  AXI data width; strobe width is DATA_WIDTH/8
// PORTS (s_* buses packed, master i at slice i; N=NUM_MASTERS, A=ADDRESS_WIDTH, D=DATA_WIDTH)
// aclk                          in   1      clock, all logic on rising edge
// aresetn                       in   1      asynchronous, active-low reset
// s_awaddr/s_awprot             in   N*A/N*3  master write addresses and protection
// s_awvalid / s_awready         in/out N/N  master AW handshake
// s_wdata/s_wstrb               in   N*D/N*D/8  master write data and strobes
// s_wvalid / s_wready           in/out N/N  master W handshake
// s_bresp / s_bvalid            out  N*2/N  master write responses
// s_bready                      in   N      master B ready
// s_araddr/s_arprot             in   N*A/N*3  master read addresses and protection
// s_arvalid / s_arready         in/out N/N  master AR handshake
// s_rdata/s_rresp/s_rvalid      out  N*D/N*2/N  master read data
// s_rready                      in   N      master R ready
// m_aw*/m_w*/m_b*/m_ar*/m_r*    mixed  -    one AXI4-Lite master port to the slave, same widths as one s_ slice
// wr_grant / rd_grant           out  N      one-hot current owner of each path (0 = none)
// BEHAVIOUR
// - Reset: all FSMs go to IDLE. Grants are 0. Both RR pointers are 0.
//   All m_*valid, m_bready, m_rready, s_*ready and s_*valid are 0 while aresetn=0.
//   Reset is asynchronous and may assert mid-transaction. The transaction is abandoned; no replay.
// - Write request i = s_awvalid[i]. Read request i = s_arvalid[i].
// - RR rule: search starts at the pointer and wraps modulo N. The first requester found wins.
//   On transaction completion the pointer becomes (winner+1) mod N.
// - Write FSM states: W_IDLE, W_ADDR, W_RESP.
//   W_IDLE: if any request is present, register wr_grant and go to W_ADDR.
//     Grant latency is 1 cycle from request to m_awvalid.
//   W_ADDR: m_aw*/m_w* are combinationally muxed from the granted slice.
//     m_awvalid = s_awvalid[g] & !aw_done. m_wvalid = s_wvalid[g] & !w_done.
//     s_awready[g] = m_awready & !aw_done. s_wready[g] = m_wready & !w_done.
//     aw_done/w_done set on their handshakes. AW and W may complete in either order or the same cycle.
//     When both are done, go to W_RESP and clear the done flags.
//   W_RESP: s_bvalid[g] = m_bvalid, s_bresp[g] = m_bresp, m_bready = s_bready[g].
//     On the B handshake: advance the pointer, clear wr_grant, go to W_IDLE.
// - Read FSM states: R_IDLE, R_ADDR, R_DATA.
//   R_IDLE -> R_ADDR on a request, with a registered rd_grant.
//   R_ADDR: AR is muxed from the granted slice. On the AR handshake go to R_DATA.
//   R_DATA: R is routed to the granted slice. On the R handshake advance the pointer and go to R_IDLE.
// - Non-granted masters see ready=0 and valid=0 on every channel. Their requests are held, never dropped.
// - Read and write paths may be granted to different or the same masters at the same time.
// - Requests arriving in the completion cycle are evaluated next cycle in IDLE against the updated pointer.
// - Fairness: with all N masters requesting continuously, each is granted once per N transactions.
// - The slave side always sees legal AXI: valid is never dropped before ready because masters hold it.
// - No combinational path from m_*ready to m_*valid.
// TESTING
// 1 Reset: aresetn=0 with s_awvalid=2'b11 -> all valid/ready outputs 0, wr_grant=0. Release -> grant 2'b01.
// 2 Single write: M1 writes addr 0x10 data 0xA5A5A5A5 strb 0xF, slave bresp=OKAY
//   -> m_awaddr=0x10 one cycle after awvalid; M1 sees bresp=0 on s_bvalid[1]; M0 sees nothing.
// 3 Contention: M0 and M1 write continuously for 4 transactions -> grant order 0,1,0,1; pointer wraps.
// 4 W before AW: M0 wvalid 3 cycles before awvalid, slave ready delayed 2 cycles
//   -> both handshakes complete once each; exactly one m_bvalid routed back.
// 5 Concurrent: M0 reads 0x20 (rdata 0x1234, SLVERR) while M1 writes
//   -> rd_grant=01 and wr_grant=10 together; M0 gets rresp=2'b10.
// 6 Mid-op reset: aresetn falls during W_RESP with m_bvalid=1 -> s_bvalid=0 at once; IDLE after release.

Source files
------------

// File: rtl/axi4_lite_rr_arbiter_if.sv
// Bus bundle for the AXI4-Lite round-robin arbiter: N packed upstream ports
// (master i at slice i) plus the single downstream port to the shared slave.
interface axi4_lite_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  localparam int unsigned N  = NUM_MASTERS;
  localparam int unsigned A  = ADDRESS_WIDTH;
  localparam int unsigned D  = DATA_WIDTH;
  localparam int unsigned SW = DATA_WIDTH / 8;

  logic [N*A-1:0]  s_awaddr;
  logic [N*3-1:0]  s_awprot;
  logic [N-1:0]    s_awvalid;
  logic [N-1:0]    s_awready;
  logic [N*D-1:0]  s_wdata;
  logic [N*SW-1:0] s_wstrb;
  logic [N-1:0]    s_wvalid;
  logic [N-1:0]    s_wready;
  logic [N*2-1:0]  s_bresp;
  logic [N-1:0]    s_bvalid;
  logic [N-1:0]    s_bready;
  logic [N*A-1:0]  s_araddr;
  logic [N*3-1:0]  s_arprot;
  logic [N-1:0]    s_arvalid;
  logic [N-1:0]    s_arready;
  logic [N*D-1:0]  s_rdata;
  logic [N*2-1:0]  s_rresp;
  logic [N-1:0]    s_rvalid;
  logic [N-1:0]    s_rready;

  logic [A-1:0]    m_awaddr;
  logic [2:0]      m_awprot;
  logic            m_awvalid;
  logic            m_awready;
  logic [D-1:0]    m_wdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_wvalid;
  logic            m_wready;
  logic [1:0]      m_bresp;
  logic            m_bvalid;
  logic            m_bready;
  logic [A-1:0]    m_araddr;
  logic [2:0]      m_arprot;
  logic            m_arvalid;
  logic            m_arready;
  logic [D-1:0]    m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rvalid;
  logic            m_rready;

  // Arbiter view: slave to the upstream masters, master to the downstream slave.
  modport slave (
    input  s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arprot, s_arvalid, s_rready,
           m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
           m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arprot, m_arvalid, m_rready
  );

  // Environment view: the upstream masters and the downstream slave together.
  modport master (
    output s_awaddr, s_awprot, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arprot, s_arvalid, s_rready,
           m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
           m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arprot, m_arvalid, m_rready
  );
endinterface

// File: rtl/axi4_lite_rr_arbiter.sv
// Shares one AXI4-Lite slave between NUM_MASTERS masters; independent round-robin
// write and read paths, each with a single transaction in flight.
module axi4_lite_rr_arbiter #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  axi4_lite_rr_arbiter_if.slave   bus,
  output logic [NUM_MASTERS-1:0]  wr_grant,
  output logic [NUM_MASTERS-1:0]  rd_grant
);
  localparam int unsigned N  = NUM_MASTERS;
  localparam int unsigned A  = ADDRESS_WIDTH;
  localparam int unsigned D  = DATA_WIDTH;
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t      w_state, w_state_d;
  r_state_t      r_state, r_state_d;
  logic [IW-1:0] w_idx, w_idx_d, w_ptr, w_ptr_d;
  logic [IW-1:0] r_idx, r_idx_d, r_ptr, r_ptr_d;
  logic [N-1:0]  wr_grant_d, rd_grant_d;
  logic          aw_done, aw_done_d, w_done, w_done_d;
  logic          aw_hs, w_hs;

  // First requester at or after ptr, wrapping modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic          found;
    win   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] idx);
    return (32'(idx) == N - 1) ? '0 : IW'(32'(idx) + 1);
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      w_idx    <= '0;
      w_ptr    <= '0;
      r_idx    <= '0;
      r_ptr    <= '0;
      wr_grant <= '0;
      rd_grant <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      w_state  <= w_state_d;
      r_state  <= r_state_d;
      w_idx    <= w_idx_d;
      w_ptr    <= w_ptr_d;
      r_idx    <= r_idx_d;
      r_ptr    <= r_ptr_d;
      wr_grant <= wr_grant_d;
      rd_grant <= rd_grant_d;
      aw_done  <= aw_done_d;
      w_done   <= w_done_d;
    end
  end

  // Write path: grant, AW/W in any order, then route B back to the owner.
  always_comb begin
    w_state_d     = w_state;
    w_idx_d       = w_idx;
    w_ptr_d       = w_ptr;
    wr_grant_d    = wr_grant;
    aw_done_d     = aw_done;
    w_done_d      = w_done;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    bus.m_awaddr  = bus.s_awaddr[32'(w_idx) * A +: A];
    bus.m_awprot  = bus.s_awprot[32'(w_idx) * 3 +: 3];
    bus.m_wdata   = bus.s_wdata[32'(w_idx) * D +: D];
    bus.m_wstrb   = bus.s_wstrb[32'(w_idx) * SW +: SW];
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.m_bready  = 1'b0;
    bus.s_awready = '0;
    bus.s_wready  = '0;
    bus.s_bvalid  = '0;
    bus.s_bresp   = '0;
    case (w_state)
      W_IDLE: begin
        if (|bus.s_awvalid) begin
          w_idx_d    = rr_pick(bus.s_awvalid, w_ptr);
          wr_grant_d = N'(1) << w_idx_d;
          w_state_d  = W_ADDR;
        end
      end
      W_ADDR: begin
        bus.m_awvalid        = bus.s_awvalid[w_idx] & ~aw_done;
        bus.m_wvalid         = bus.s_wvalid[w_idx] & ~w_done;
        bus.s_awready[w_idx] = bus.m_awready & ~aw_done;
        bus.s_wready[w_idx]  = bus.m_wready & ~w_done;
        aw_hs                = bus.s_awvalid[w_idx] & ~aw_done & bus.m_awready;
        w_hs                 = bus.s_wvalid[w_idx] & ~w_done & bus.m_wready;
        aw_done_d            = aw_done | aw_hs;
        w_done_d             = w_done | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bus.s_bvalid[w_idx]               = bus.m_bvalid;
        bus.s_bresp[32'(w_idx) * 2 +: 2]  = bus.m_bresp;
        bus.m_bready                      = bus.s_bready[w_idx];
        if (bus.m_bvalid && bus.s_bready[w_idx]) begin
          w_ptr_d    = rr_next(w_idx);
          wr_grant_d = '0;
          w_state_d  = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path: grant, forward AR, then route R back to the owner.
  always_comb begin
    r_state_d     = r_state;
    r_idx_d       = r_idx;
    r_ptr_d       = r_ptr;
    rd_grant_d    = rd_grant;
    bus.m_araddr  = bus.s_araddr[32'(r_idx) * A +: A];
    bus.m_arprot  = bus.s_arprot[32'(r_idx) * 3 +: 3];
    bus.m_arvalid = 1'b0;
    bus.m_rready  = 1'b0;
    bus.s_arready = '0;
    bus.s_rvalid  = '0;
    bus.s_rdata   = '0;
    bus.s_rresp   = '0;
    case (r_state)
      R_IDLE: begin
        if (|bus.s_arvalid) begin
          r_idx_d    = rr_pick(bus.s_arvalid, r_ptr);
          rd_grant_d = N'(1) << r_idx_d;
          r_state_d  = R_ADDR;
        end
      end
      R_ADDR: begin
        bus.m_arvalid        = bus.s_arvalid[r_idx];
        bus.s_arready[r_idx] = bus.m_arready;
        if (bus.s_arvalid[r_idx] && bus.m_arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        bus.s_rvalid[r_idx]              = bus.m_rvalid;
        bus.s_rdata[32'(r_idx) * D +: D] = bus.m_rdata;
        bus.s_rresp[32'(r_idx) * 2 +: 2] = bus.m_rresp;
        bus.m_rready                     = bus.s_rready[r_idx];
        if (bus.m_rvalid && bus.s_rready[r_idx]) begin
          r_ptr_d    = rr_next(r_idx);
          rd_grant_d = '0;
          r_state_d  = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end
endmodule
